// File: rtl/udp_pkg.sv
// Shared types and constants for the UDP transmit buffer.
package udp_pkg;

    typedef enum logic [2:0] {
        UDPB_IDLE,
        UDPB_FILL,
        UDPB_DROP,
        UDPB_SEND,
        UDPB_DONE
    } udpb_state_t;

    // Header word holding {length, checksum}; the checksum half is patched on the way out
    localparam int UDP_HDR_CHK_WORD = 1;
    localparam int UDP_HDR_BYTES    = 8;

    // Byte enables for the final word, MSB is the first byte on the wire
    function automatic logic [3:0] keep_from_len(input logic [1:0] len_lsb);
        case (len_lsb)
            2'd1:    return 4'b1000;
            2'd2:    return 4'b1100;
            2'd3:    return 4'b1110;
            default: return 4'b1111;
        endcase
    endfunction

    // Number of 32-bit words a datagram of len bytes occupies (17 bits so len=0xFFFF cannot wrap)
    function automatic logic [16:0] words_from_len(input logic [15:0] len);
        return ({1'b0, len} + 17'd3) >> 2;
    endfunction

endpackage

// File: rtl/udp_tx_buffer_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
module sdp_ram #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_W];

    // Write and read ports; rdata only changes on a read so it can hold under backpressure
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/udp_tx_buffer.sv
// Store-and-forward buffer behind the UDP encoder: captures a datagram, patches
// the checksum into header word 1, then streams it out over valid/ready.
module udp_tx_buffer
    import udp_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_data,
    input  logic        in_wr,
    input  logic        in_fin,
    input  logic [15:0] in_chksum,
    input  logic [15:0] in_len,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic [3:0]  out_keep,
    output logic        done,
    output logic        ovf_err,
    output logic        len_err
);

    localparam logic [ADDR_W:0] PTR_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] CHK_IDX  = (ADDR_W+1)'(UDP_HDR_CHK_WORD);

    udpb_state_t     state, state_next;
    logic            fin_q, fin_rise;
    logic [ADDR_W:0] wr_ptr, rd_ptr, n_words, n_next, out_idx;
    logic [15:0]     chk_r, len_r;
    logic            we, re, finish, ovf_set, xfer;
    logic [31:0]     rd_q;

    assign fin_rise = in_fin & ~fin_q;
    assign n_next   = we ? wr_ptr + PTR_ONE : wr_ptr;
    assign xfer     = out_valid & out_ready;
    // Fetch the next word whenever the output slot is empty or draining this cycle
    assign re       = (state == UDPB_SEND) && (!out_valid || out_ready) && (rd_ptr < n_words);

    sdp_ram #(
        .WIDTH  (32),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (in_data),
        .re    (re),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (rd_q)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= UDPB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus write/finish/overflow strobes
    always_comb begin
        state_next = state;
        we         = 1'b0;
        finish     = 1'b0;
        ovf_set    = 1'b0;
        case (state)
            UDPB_IDLE: begin
                if (in_wr) begin
                    we = 1'b1;
                    if (fin_rise) begin
                        finish     = 1'b1;
                        state_next = UDPB_SEND;
                    end else begin
                        state_next = UDPB_FILL;
                    end
                end
            end
            UDPB_FILL: begin
                if (in_wr && wr_ptr == PTR_FULL) begin
                    // A coincident fin ends the dropped packet right away
                    ovf_set    = 1'b1;
                    state_next = fin_rise ? UDPB_IDLE : UDPB_DROP;
                end else begin
                    we = in_wr;
                    if (fin_rise) begin
                        finish     = 1'b1;
                        state_next = UDPB_SEND;
                    end
                end
            end
            UDPB_DROP: begin
                if (fin_rise) begin
                    state_next = UDPB_IDLE;
                end
            end
            UDPB_SEND: begin
                if (xfer && out_last) begin
                    state_next = UDPB_DONE;
                end
            end
            UDPB_DONE: begin
                state_next = UDPB_IDLE;
            end
            default: begin
                state_next = UDPB_IDLE;
            end
        endcase
    end

    // Pointers, latched packet info, error flags and the output valid register
    always_ff @(posedge clk) begin
        if (reset) begin
            fin_q     <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            n_words   <= '0;
            out_idx   <= '0;
            chk_r     <= '0;
            len_r     <= '0;
            out_valid <= 1'b0;
            ovf_err   <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            fin_q <= in_fin;
            if (state_next == UDPB_IDLE) begin
                wr_ptr <= '0;
            end else if (we) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (finish) begin
                chk_r   <= in_chksum;
                len_r   <= in_len;
                n_words <= n_next;
                rd_ptr  <= '0;
                if (words_from_len(in_len) != 17'(n_next)) begin
                    len_err <= 1'b1;
                end
            end else if (re) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (ovf_set) begin
                ovf_err <= 1'b1;
            end
            if (re) begin
                out_idx <= rd_ptr;
            end
            if (state != UDPB_SEND) begin
                out_valid <= 1'b0;
            end else if (re) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign in_ready = (state == UDPB_IDLE) || (state == UDPB_FILL);
    assign done     = (state == UDPB_DONE);
    assign out_last = out_valid && (out_idx == n_words - PTR_ONE);
    assign out_keep = !out_valid ? 4'b0000 :
                      out_last   ? keep_from_len(len_r[1:0]) : 4'b1111;
    assign out_data = !out_valid             ? 32'd0 :
                      (out_idx == CHK_IDX)   ? {rd_q[31:16], chk_r} : rd_q;

endmodule

// File: tb/tb_udp_tx_buffer.sv
// Directed bench for udp_tx_buffer: vector table plus hand-written corner sequences.
module tb_udp_tx_buffer;
    import udp_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic        in_wr, in_fin;
    logic [15:0] in_chksum, in_len;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid, out_ready, out_last;
    logic [3:0]  out_keep;
    logic        done, ovf_err, len_err;

    logic        s_reset;
    logic [31:0] s_in_data;
    logic        s_in_wr, s_in_fin;
    logic [15:0] s_in_chksum, s_in_len;
    logic        s_in_ready;
    logic [31:0] s_out_data;
    logic        s_out_valid, s_out_ready, s_out_last;
    logic [3:0]  s_out_keep;
    logic        s_done, s_ovf_err, s_len_err;

    always #5 clk = ~clk;

    udp_tx_buffer #(.ADDR_W(9)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_wr(in_wr), .in_fin(in_fin),
        .in_chksum(in_chksum), .in_len(in_len), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .out_keep(out_keep),
        .done(done), .ovf_err(ovf_err), .len_err(len_err)
    );

    udp_tx_buffer #(.ADDR_W(3)) dut_small (
        .clk(clk), .reset(s_reset), .in_data(s_in_data), .in_wr(s_in_wr), .in_fin(s_in_fin),
        .in_chksum(s_in_chksum), .in_len(s_in_len), .in_ready(s_in_ready), .out_data(s_out_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_last(s_out_last), .out_keep(s_out_keep),
        .done(s_done), .ovf_err(s_ovf_err), .len_err(s_len_err)
    );

    typedef struct packed {
        logic [3:0]       n;
        logic             merge;
        logic [3:0][31:0] w;
        logic [3:0][31:0] e;
        logic [15:0]      chk;
        logic [15:0]      len;
        logic [3:0]       keep;
        logic             lerr;
    } vec_t;

    int checks = 0;
    int failures = 0;

    logic [31:0] tx_words [32];
    logic [31:0] exp_words [32];
    int          tx_n;

    logic [31:0] got_data [64];
    logic        got_last [64];
    logic [3:0]  got_keep [64];
    int          got_n, ndone, first_valid, stall_err, done_k, bad_done;
    logic        ready_after;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input int n, input bit merge,
                                input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [31:0] w3,
                                input logic [31:0] e1, input logic [15:0] chk,
                                input logic [15:0] len, input logic [3:0] keep, input bit lerr);
        vec_t v;
        v.n     = 4'(n);
        v.merge = merge;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
        v.e[0] = w0; v.e[1] = e1; v.e[2] = w2; v.e[3] = w3;
        v.chk   = chk;
        v.len   = len;
        v.keep  = keep;
        v.lerr  = lerr;
        return v;
    endfunction

    task automatic doReset();
        reset = 1'b1; s_reset = 1'b1;
        in_wr = 1'b0; in_fin = 1'b0; in_data = '0; in_chksum = '0; in_len = '0; out_ready = 1'b1;
        s_in_wr = 1'b0; s_in_fin = 1'b0; s_in_data = '0; s_in_chksum = 16'h1111; s_in_len = '0;
        s_out_ready = 1'b1;
        step();
        step();
        reset = 1'b0; s_reset = 1'b0;
    endtask

    task automatic checkResetState(input string name);
        checkOutput({name, "_valid"}, 32'(out_valid), 32'd0);
        checkOutput({name, "_last"},  32'(out_last),  32'd0);
        checkOutput({name, "_done"},  32'(done),      32'd0);
        checkOutput({name, "_data"},  out_data,       32'd0);
        checkOutput({name, "_keep"},  32'(out_keep),  32'd0);
        checkOutput({name, "_ready"}, 32'(in_ready),  32'd1);
        checkOutput({name, "_ovf"},   32'(ovf_err),   32'd0);
        checkOutput({name, "_lerr"},  32'(len_err),   32'd0);
    endtask

    // merge raises fin in the same cycle as the final write
    task automatic sendPacket(input logic [15:0] chk, input logic [15:0] len, input bit merge);
        in_chksum = chk;
        in_len    = len;
        for (int i = 0; i < tx_n; i++) begin
            in_data = tx_words[i];
            in_wr   = 1'b1;
            in_fin  = (merge && i == tx_n - 1);
            step();
        end
        in_wr = 1'b0;
        if (!(merge && tx_n > 0)) begin
            in_fin = 1'b1;
            step();
        end
    endtask

    task automatic receivePacket(input bit rnd, input int tail);
        logic        held;
        logic [31:0] hd;
        logic        hl;
        logic [3:0]  hk;
        got_n = 0; ndone = 0; first_valid = -1; stall_err = 0; done_k = -1; bad_done = 0;
        ready_after = 1'b0;
        held = 1'b0; hd = '0; hl = 1'b0; hk = '0;
        for (int k = 0; k < 400 && !(done_k >= 0 && k > done_k + tail); k++) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (held && (!out_valid || out_data !== hd || out_last !== hl || out_keep !== hk)) begin
                stall_err++;
            end
            if (out_valid && first_valid < 0) first_valid = k;
            held = 1'b0;
            if (out_valid && out_ready) begin
                if (got_n < 64) begin
                    got_data[got_n] = out_data;
                    got_last[got_n] = out_last;
                    got_keep[got_n] = out_keep;
                end
                got_n++;
            end else if (out_valid) begin
                held = 1'b1; hd = out_data; hl = out_last; hk = out_keep;
            end
            if (done_k >= 0 && k == done_k + 1) ready_after = in_ready;
            if (done) begin
                ndone++;
                if (done_k < 0) done_k = k;
                if (out_valid || in_ready) bad_done++;
            end
            step();
        end
        out_ready = 1'b1;
        checkOutput("done_seen", 32'(done_k >= 0), 32'd1);
    endtask

    task automatic checkPacket(input string name, input logic [3:0] keep_last, input logic lerr);
        int nbad;
        nbad = 0;
        for (int i = 0; i < got_n && i < tx_n && i < 64; i++) begin
            logic       el;
            logic [3:0] ek;
            el = (i == tx_n - 1);
            ek = el ? keep_last : 4'b1111;
            if (got_data[i] !== exp_words[i] || got_last[i] !== el || got_keep[i] !== ek) begin
                if (nbad == 0)
                    $display("[TB] %s word %0d: data 0x%0h/0x%0h last %0b/%0b keep %b/%b", name, i,
                             got_data[i], exp_words[i], got_last[i], el, got_keep[i], ek);
                nbad++;
            end
        end
        checkOutput({name, "_count"},     32'(got_n),       32'(tx_n));
        checkOutput({name, "_word_errs"}, 32'(nbad),        32'd0);
        checkOutput({name, "_dones"},     32'(ndone),       32'd1);
        checkOutput({name, "_latency"},   32'(first_valid), 32'd1);
        checkOutput({name, "_stall"},     32'(stall_err),   32'd0);
        checkOutput({name, "_done_cyc"},  32'(bad_done),    32'd0);
        checkOutput({name, "_rdy_after"}, 32'(ready_after), 32'd1);
        checkOutput({name, "_len_err"},   32'(len_err),     32'(lerr));
        checkOutput({name, "_ovf_err"},   32'(ovf_err),     32'd0);
    endtask

    task automatic applyStimulus(input vec_t v, input string name);
        tx_n = int'(v.n);
        for (int i = 0; i < tx_n; i++) begin
            tx_words[i]  = v.w[i];
            exp_words[i] = v.e[i];
        end
        sendPacket(v.chk, v.len, v.merge);
        receivePacket(1'b0, 3);
        checkPacket(name, v.keep, v.lerr);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs [7];
        int   xf, dn, vc;

        vecs[0] = mk(4, 0, 32'h1234_0050, 32'h000C_0000, 32'hDEAD_BEEF, 32'hCAFE_0000,
                     32'h000C_A5A5, 16'hA5A5, 16'd12, 4'b1111, 1);
        vecs[1] = mk(3, 0, 32'h1234_0050, 32'h000C_0000, 32'hDEAD_BEEF, 32'h0,
                     32'h000C_A5A5, 16'hA5A5, 16'd12, 4'b1111, 0);
        vecs[2] = mk(4, 0, 32'h1111_2222, 32'h000D_0000, 32'h0102_0304, 32'hAB00_0000,
                     32'h000D_1234, 16'h1234, 16'd13, 4'b1000, 0);
        vecs[3] = mk(2, 0, 32'hAAAA_BBBB, 32'h0006_0000, 32'h0, 32'h0,
                     32'h0006_0000, 16'h0000, 16'd6, 4'b1100, 0);
        vecs[4] = mk(1, 0, 32'h5566_7700, 32'h0, 32'h0, 32'h0,
                     32'h0, 16'hF00D, 16'd3, 4'b1110, 0);
        vecs[5] = mk(3, 1, 32'h0A0B_0C0D, 32'h000B_0000, 32'h9988_7766, 32'h0,
                     32'h000B_FFFF, 16'hFFFF, 16'd11, 4'b1110, 0);
        vecs[6] = mk(2, 0, 32'h0101_0101, 32'h000C_0000, 32'h0, 32'h0,
                     32'h000C_0001, 16'h0001, 16'd12, 4'b1111, 1);

        reset = 1'b1; s_reset = 1'b1;
        in_wr = 1'b0; in_fin = 1'b0; in_data = '0; in_chksum = '0; in_len = '0; out_ready = 1'b1;
        s_in_wr = 1'b0; s_in_fin = 1'b0; s_in_data = '0; s_in_chksum = '0; s_in_len = '0;
        s_out_ready = 1'b1;
        step();
        checkResetState("reset");

        $display("[TB] vector table");
        for (int v = 0; v < 7; v++) begin
            doReset();
            applyStimulus(vecs[v], $sformatf("vec%0d", v));
        end

        $display("[TB] backpressure, 20 words");
        doReset();
        tx_n = 20;
        for (int i = 0; i < 20; i++) begin
            tx_words[i]  = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
            exp_words[i] = tx_words[i];
        end
        tx_words[1]  = {16'(UDP_HDR_BYTES + 70), 16'h0000};
        exp_words[1] = {16'(UDP_HDR_BYTES + 70), 16'h3C3C};
        sendPacket(16'h3C3C, 16'(UDP_HDR_BYTES + 70), 1'b0);
        receivePacket(1'b1, 3);
        checkPacket("bp", 4'b1100, 1'b0);

        $display("[TB] sticky fin then back-to-back");
        doReset();
        tx_n = 3;
        for (int i = 0; i < 3; i++) begin
            tx_words[i]  = vecs[1].w[i];
            exp_words[i] = vecs[1].e[i];
        end
        sendPacket(16'hA5A5, 16'd12, 1'b0);
        receivePacket(1'b0, 12);
        checkPacket("sticky", 4'b1111, 1'b0);
        applyStimulus(vecs[2], "b2b");

        $display("[TB] reset during SEND");
        doReset();
        tx_n = 5;
        for (int i = 0; i < 5; i++) tx_words[i] = 32'hC0DE_0000 + 32'(i);
        sendPacket(16'h7777, 16'd20, 1'b0);
        xf = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && xf < 2; k++) begin
            if (out_valid) xf++;
            step();
        end
        checkOutput("rst_xfers", 32'(xf), 32'd2);
        reset = 1'b1;
        in_fin = 1'b0;
        step();
        checkResetState("midsend");
        reset = 1'b0;
        step();
        applyStimulus(vecs[1], "after_rst");

        $display("[TB] small buffer: exact fill then overflow");
        doReset();
        for (int i = 0; i < 8; i++) begin
            s_in_data = 32'h100 + 32'(i);
            s_in_wr = 1'b1;
            step();
        end
        s_in_wr = 1'b0; s_in_fin = 1'b1; s_in_len = 16'd32;
        step();
        xf = 0; dn = 0;
        for (int k = 0; k < 30; k++) begin
            if (s_out_valid && s_out_ready) xf++;
            if (s_done) dn++;
            step();
        end
        checkOutput("full_count", 32'(xf), 32'd8);
        checkOutput("full_done",  32'(dn), 32'd1);
        checkOutput("full_ovf",   32'(s_ovf_err), 32'd0);
        checkOutput("full_lerr",  32'(s_len_err), 32'd0);

        for (int i = 0; i < 9; i++) begin
            s_in_data = 32'h200 + 32'(i);
            s_in_wr = 1'b1;
            s_in_fin = 1'b0;
            step();
        end
        s_in_wr = 1'b0;
        checkOutput("ovf_flag",       32'(s_ovf_err),  32'd1);
        checkOutput("ovf_drop_ready", 32'(s_in_ready), 32'd0);
        s_in_fin = 1'b1; s_in_len = 16'd36;
        step();
        vc = 0; dn = 0;
        for (int k = 0; k < 15; k++) begin
            if (s_out_valid) vc++;
            if (s_done) dn++;
            step();
        end
        checkOutput("ovf_valids", 32'(vc), 32'd0);
        checkOutput("ovf_dones",  32'(dn), 32'd0);
        checkOutput("ovf_idle",   32'(s_in_ready), 32'd1);
        checkOutput("ovf_sticky", 32'(s_ovf_err),  32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
